// File: rtl/iobuff_pkg.sv
// rtl/iobuff_pkg.sv - shared state type and defaults for the iobuff pin driver and receiver
package iobuff_pkg;

  typedef enum logic [1:0] {
    BLANK   = 2'd0,
    TRACK   = 2'd1,
    QUALIFY = 2'd2
  } iobuff_state_e;

  localparam int   FILT_W_DEF       = 8;
  localparam int   CNT_W_DEF        = 16;
  localparam int   BLANK_CYCLES_DEF = 4;
  localparam logic IDLE_LVL         = 1'b1;

  // Bits needed for a counter that must hold every value 0..max_val.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with configurable reset value for asynchronous pin inputs
module sync2
  import iobuff_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{IDLE_LVL}}
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/iobuff_rx.sv
// rtl/iobuff_rx.sv - pin receiver: sync, turnaround blanking, glitch filter, edge pulses (optional IOBUFF_RX_EDGE_COUNT_EN)
module iobuff_rx
  import iobuff_pkg::*;
#(
  parameter int   FILT_W       = FILT_W_DEF,
  parameter int   BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int   CNT_W        = CNT_W_DEF,
  parameter logic RST_VAL      = IDLE_LVL
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pin_din_i,
  input  logic              bufdir_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              cnt_clr_i,
  output logic              dout_o,
  output logic              valid_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic [CNT_W-1:0]  edge_count_o
);

  localparam int               BLANK_W    = cnt_bits(BLANK_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);

  iobuff_state_e     state_q, state_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              bufdir_q;
  logic              pin_s;
  logic              dir_chg;

  sync2 #(
    .W       (1),
    .RST_VAL (RST_VAL)
  ) u_pin_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pin_din_i),
    .q_o   (pin_s)
  );

  // Any direction change means the level shifter is turning around.
  assign dir_chg = bufdir_i ^ bufdir_q;

  // State, filter and pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= BLANK;
      blank_q  <= BLANK_LOAD;
      cnt_q    <= '0;
      dout_q   <= RST_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      bufdir_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      blank_q  <= blank_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      bufdir_q <= bufdir_i;
    end
  end

  // Next state: blank during turnaround, then commit a new level once it is stable long enough.
  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      BLANK: begin
        cnt_d = '0;
        if (dir_chg) begin
          blank_d = BLANK_LOAD;
        end else begin
          blank_d = blank_q - BLANK_W'(1);
          if (blank_q == BLANK_W'(1)) begin
            state_d = TRACK;
          end
        end
      end
      TRACK: begin
        if (dir_chg) begin
          state_d = BLANK;
          blank_d = BLANK_LOAD;
        end else if (pin_s != dout_q) begin
          if (filt_len_i == '0) begin
            dout_d = pin_s;
            rise_d = pin_s;
            fall_d = ~pin_s;
          end else begin
            state_d = QUALIFY;
            cnt_d   = FILT_W'(1);
          end
        end
      end
      QUALIFY: begin
        if (dir_chg) begin
          state_d = BLANK;
          blank_d = BLANK_LOAD;
          cnt_d   = '0;
        end else if (pin_s == dout_q) begin
          state_d = TRACK;
          cnt_d   = '0;
        end else if (cnt_q >= filt_len_i) begin
          // >= lets a lowered filt_len finish the pending qualification at once.
          state_d = TRACK;
          cnt_d   = '0;
          dout_d  = pin_s;
          rise_d  = pin_s;
          fall_d  = ~pin_s;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + FILT_W'(1);
        end
      end
      default: begin
        state_d = BLANK;
        blank_d = BLANK_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout_o  = dout_q;
  assign valid_o = (state_q != BLANK);
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef IOBUFF_RX_EDGE_COUNT_EN
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  // Count commits alongside dout; clear wins over a coincident edge.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (cnt_clr_i) begin
      edge_cnt_d = '0;
    end else if (rise_d | fall_d) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // Edge counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_count_o = edge_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign edge_count_o   = '0;
`endif

endmodule

// File: tb/tb_iobuff_rx.sv
// tb/tb_iobuff_rx.sv - randomized scoreboard bench for iobuff_rx
module tb_iobuff_rx;

  localparam int BLANK = 4;
  localparam int CW    = 4;
  localparam int MAXC  = 60000;
`ifdef IOBUFF_RX_EDGE_COUNT_EN
  localparam int EC_ON = 1;
`else
  localparam int EC_ON = 0;
`endif

  typedef struct {
    bit is_rise;
    int n;
  } pulse_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pin = 1'b1;
  logic          bufdir = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [7:0]    filt_len = 8'd0;
  logic          dout, valid, rise, fall;
  logic [CW-1:0] edge_count;

  int     vectors = 0;
  int     miscompares = 0;
  pulse_t sb[$];
  int     cyc = 0;
  bit     pin_log[MAXC];
  bit     dir_log[MAXC];
  int     last_rst = 0;
  int     t_blank = 0;
  int     run = 0;
  bit     m_dout = 1'b1;
  bit     m_valid = 1'b0;
  int     m_cnt = 0;

  iobuff_rx #(.CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pin_din_i    (pin),
    .bufdir_i     (bufdir),
    .filt_len_i   (filt_len),
    .cnt_clr_i    (cnt_clr),
    .dout_o       (dout),
    .valid_o      (valid),
    .rise_o       (rise),
    .fall_o       (fall),
    .edge_count_o (edge_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: s is the pin two edges ago, blanking lasts BLANK cycles after the
  // latest reset/direction-change edge, and a new level commits once it has
  // differed from dout for more than filt_len consecutive tracking cycles.
  always @(posedge clk) begin
    int s;
    int bq;
    bit dchg;
    bit was_valid;
    bit commit;
    pulse_t p;
    cyc++;
    if (cyc < MAXC) begin
      pin_log[cyc] = pin;
      dir_log[cyc] = bufdir;
    end
    if (rst) begin
      last_rst = cyc;
      t_blank  = cyc;
      run      = 0;
      m_dout   = 1'b1;
      m_valid  = 1'b0;
      m_cnt    = 0;
    end else begin
      s         = (last_rst >= cyc - 2) ? 1 : int'(pin_log[cyc - 2]);
      bq        = (last_rst >= cyc - 1) ? 0 : int'(dir_log[cyc - 1]);
      dchg      = (int'(bufdir) != bq);
      was_valid = m_valid;
      commit    = 1'b0;
      if (dchg) begin
        t_blank = cyc;
        run     = 0;
      end else if (was_valid) begin
        if (s != int'(m_dout)) begin
          run++;
          if (run > int'(filt_len)) begin
            commit = 1'b1;
            m_dout = s[0];
            run    = 0;
          end
        end else begin
          run = 0;
        end
      end
      m_valid = ((cyc - t_blank) >= BLANK);
      if (commit) begin
        p.is_rise = m_dout;
        p.n       = cyc;
        sb.push_back(p);
      end
      if (EC_ON != 0) begin
        if (cnt_clr) m_cnt = 0;
        else if (commit) m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
  end

  // Monitor: compare levels every cycle and pop expected pulses when the DUT shows one.
  always @(negedge clk) begin
    chk("valid", int'(valid), int'(m_valid));
    chk("dout", int'(dout), int'(m_dout));
    chk("edge_count", int'(edge_count), m_cnt);
    chk("rise_fall_exclusive", int'(rise & fall), 0);
    while (sb.size() > 0 && sb[0].n < cyc) begin
      chk("missing_pulse_cycle", cyc, sb[0].n);
      void'(sb.pop_front());
    end
    if (rise || fall) begin
      if (sb.size() == 0 || sb[0].n != cyc) begin
        chk("unexpected_pulse", int'(rise | fall), 0);
      end else begin
        chk("pulse_is_rise", int'(rise), int'(sb[0].is_rise));
        void'(sb.pop_front());
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int r;
    rst = 1'b1; pin = 1'b1; bufdir = 1'b0; filt_len = 8'd0; cnt_clr = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(12);

    // Filtered fall: dout changes on the sixth edge after the pin edge.
    filt_len = 8'd3;
    cycles(2);
    pin = 1'b0;
    cycles(5);
    chk("lat_dout_before", int'(dout), 1);
    cycles(1);
    chk("lat_dout_after", int'(dout), 0);
    chk("lat_fall", int'(fall), 1);
    pin = 1'b1;
    cycles(10);

    // Three-cycle low glitch is rejected.
    pin = 1'b0;
    cycles(3);
    pin = 1'b1;
    cycles(12);
    chk("glitch_dout", int'(dout), 1);

    // Direction change while qualifying: blank, then requalify.
    filt_len = 8'd5;
    pin = 1'b0;
    cycles(5);
    bufdir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      chk("turn_valid_low", int'(valid), 0);
      chk("turn_no_fall", int'(fall), 0);
    end
    cycles(1);
    chk("turn_valid_back", int'(valid), 1);
    cycles(5);
    chk("requal_dout_before", int'(dout), 1);
    cycles(1);
    chk("requal_dout_after", int'(dout), 0);
    chk("requal_fall", int'(fall), 1);
    pin = 1'b1;
    filt_len = 8'd0;
    cycles(8);

    // Edge counting, clear coincident with an edge, and wrap at CW bits.
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pin = ~pin;
      cycles(5);
    end
    chk("count_five", int'(edge_count), 5 * EC_ON);
    pin = ~pin;
    cycles(2);
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    chk("clr_beats_edge", int'(edge_count), 0);
    for (int i = 0; i < 15; i++) begin
      pin = ~pin;
      cycles(4);
    end
    chk("count_fifteen", int'(edge_count), 15 * EC_ON);
    pin = ~pin;
    cycles(4);
    chk("count_wrap", int'(edge_count), 0);

    // Asynchronous reset while qualifying a rise.
    pin = 1'b0;
    cycles(6);
    filt_len = 8'd20;
    pin = 1'b1;
    cycles(6);
    chk("pre_rst_valid", int'(valid), 1);
    chk("pre_rst_dout", int'(dout), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dout", int'(dout), 1);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_rise", int'(rise), 0);
    chk("async_rst_fall", int'(fall), 0);
    chk("async_rst_count", int'(edge_count), 0);
    cycles(2);
    rst = 1'b0;
    filt_len = 8'd0;
    cycles(10);

    // Random pin activity, direction changes, filter lengths and clears.
    for (int it = 0; it < 1500; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) pin = ~pin;
      else if (r < 55) bufdir = ~bufdir;
      else if (r < 65) filt_len = 8'($urandom_range(0, 6));
      else if (r < 70) cnt_clr = 1'b1;
      cycles(int'($urandom_range(1, 10)));
      cnt_clr = 1'b0;
    end

    filt_len = 8'd0;
    cycles(30);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
